// File: rtl/nodf_module_intf_pkg.sv
// Shared types and defaults for the nodf_module_intf ap_ctrl status monitor.
package nodf_module_intf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one; never wraps.
module nodf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_one,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_inc
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Exposed so callers can capture "value including this cycle" without an extra adder.
    assign count_inc = (count == ALL_ONES) ? count : count + ONE;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= ONE;
        end else if (enable) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl handshake monitor: transaction FSM, saturating counters, latency stats.
// min/max latency tracking is built only when NODF_MODULE_INTF_LATENCY_EN is defined.
module nodf_module_intf
    import nodf_module_intf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] txn_started,
    output logic [CNT_W-1:0] txn_done,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic             latency_valid,
    output logic             finished,
    output logic             protocol_err
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           st;
    logic             live;
    logic             in_idle;
    logic             complete_now;
    logic [CNT_W-1:0] lat_count;
    logic [CNT_W-1:0] lat_inc;
    logic [CNT_W-1:0] lat_value;
    logic [CNT_W-1:0] started_inc;
    logic [CNT_W-1:0] done_inc;
    logic [CNT_W-1:0] busy_inc;
    logic [CNT_W-1:0] stall_inc;

    assign state   = st;
    assign live    = !finished;
    assign in_idle = (st == ST_IDLE);

    // Latency reported at completion counts the completion cycle itself.
    always_comb begin
        complete_now = 1'b0;
        lat_value    = lat_inc;
        case (st)
            ST_IDLE: begin
                complete_now = ap_start && ap_done && ap_continue;
                lat_value    = ONE;
            end
            ST_RUN:       complete_now = ap_done && ap_continue;
            ST_DONE_WAIT: complete_now = ap_continue;
            default:      complete_now = 1'b0;
        endcase
    end

    nodf_sat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clock(clock), .reset(reset), .clear(1'b0),
        .load_one(live && in_idle && ap_start), .enable(live && !in_idle),
        .count(lat_count), .count_inc(lat_inc)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_started_cnt (
        .clock(clock), .reset(reset), .clear(1'b0),
        .load_one(1'b0), .enable(live && ap_start && ap_ready),
        .count(txn_started), .count_inc(started_inc)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_done_cnt (
        .clock(clock), .reset(reset), .clear(1'b0),
        .load_one(1'b0), .enable(live && complete_now),
        .count(txn_done), .count_inc(done_inc)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
        .clock(clock), .reset(reset), .clear(1'b0),
        .load_one(1'b0), .enable(live && !in_idle),
        .count(busy_cycles), .count_inc(busy_inc)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .clear(1'b0),
        .load_one(1'b0), .enable(live && ap_done && !ap_continue),
        .count(stall_cycles), .count_inc(stall_inc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            st            <= ST_IDLE;
            last_latency  <= '0;
            latency_valid <= 1'b0;
            finished      <= 1'b0;
            protocol_err  <= 1'b0;
`ifdef NODF_MODULE_INTF_LATENCY_EN
            min_latency   <= {CNT_W{1'b1}};
            max_latency   <= '0;
`endif
        end else begin
            // Observational only: flags the error, FSM carries on unchanged.
            if (in_idle && ap_done && !ap_start) begin
                protocol_err <= 1'b1;
            end
            if (live) begin
                if (finish) begin
                    finished <= 1'b1;
                end
                if (complete_now) begin
                    last_latency  <= lat_value;
                    latency_valid <= 1'b1;
`ifdef NODF_MODULE_INTF_LATENCY_EN
                    if (lat_value < min_latency) min_latency <= lat_value;
                    if (lat_value > max_latency) max_latency <= lat_value;
`endif
                end
                case (st)
                    ST_IDLE: begin
                        if (ap_start) begin
                            if (!ap_done)         st <= ST_RUN;
                            else if (!ap_continue) st <= ST_DONE_WAIT;
                        end
                    end
                    ST_RUN: begin
                        if (ap_done) st <= ap_continue ? ST_IDLE : ST_DONE_WAIT;
                    end
                    ST_DONE_WAIT: begin
                        if (ap_continue) st <= ST_IDLE;
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

`ifndef NODF_MODULE_INTF_LATENCY_EN
    assign min_latency = {CNT_W{1'b1}};
    assign max_latency = '0;
`endif

endmodule

// File: tb/tb_nodf_module_intf.sv
// Self-checking bench for nodf_module_intf: directed scenarios plus random ap_ctrl traffic
// against a cycle-stamp reference model (latency = completion cycle - start cycle + 1).
module tb_nodf_module_intf;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]       state;
  logic [CNT_W-1:0] txn_started, txn_done, busy_cycles, stall_cycles;
  logic [CNT_W-1:0] last_latency, min_latency, max_latency;
  logic             latency_valid, finished, protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_state, m_started, m_done, m_busy, m_stall, m_last, m_min, m_max;
  int m_valid, m_fin, m_perr, m_cyc, m_start_cyc;
  logic [CNT_W-1:0] exp_q[$];

  nodf_module_intf #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .txn_started(txn_started), .txn_done(txn_done),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
    .last_latency(last_latency), .min_latency(min_latency), .max_latency(max_latency),
    .latency_valid(latency_valid), .finished(finished), .protocol_err(protocol_err)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_started = 0; m_done = 0; m_busy = 0; m_stall = 0;
    m_last = 0; m_min = SAT; m_max = 0; m_valid = 0; m_fin = 0; m_perr = 0;
    m_cyc = 0; m_start_cyc = 0;
  endtask

  task automatic model_complete();
    int lat;
    lat = sat(m_cyc - m_start_cyc + 1);
    m_done  = sat(m_done + 1);
    m_last  = lat;
    m_valid = 1;
    if (lat < m_min) m_min = lat;
    if (lat > m_max) m_max = lat;
    exp_q.push_back(CNT_W'(lat));
    m_state = 0;
  endtask

  task automatic model_step();
    int prev;
    if (!reset) begin
      model_reset();
      return;
    end
    prev = m_state;
    if (prev == 0 && ap_done && !ap_start) m_perr = 1;
    if (m_fin == 0) begin
      if (ap_start && ap_ready) m_started = sat(m_started + 1);
      if (ap_done && !ap_continue) m_stall = sat(m_stall + 1);
      if (prev != 0) m_busy = sat(m_busy + 1);
      if (prev == 0) begin
        if (ap_start) begin
          m_start_cyc = m_cyc;
          if (ap_done && ap_continue) model_complete();
          else if (ap_done) m_state = 2;
          else m_state = 1;
        end
      end else if (prev == 1) begin
        if (ap_done) begin
          if (ap_continue) model_complete();
          else m_state = 2;
        end
      end else begin
        if (ap_continue) model_complete();
      end
      if (finish) m_fin = 1;
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check("state", 64'(state), 64'(m_state));
    check("txn_started", 64'(txn_started), 64'(m_started));
    check("txn_done", 64'(txn_done), 64'(m_done));
    check("busy_cycles", 64'(busy_cycles), 64'(m_busy));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check("latency_valid", 64'(latency_valid), 64'(m_valid));
    check("finished", 64'(finished), 64'(m_fin));
    check("protocol_err", 64'(protocol_err), 64'(m_perr));
`ifdef NODF_MODULE_INTF_LATENCY_EN
    check("min_latency", 64'(min_latency), 64'(m_min));
    check("max_latency", 64'(max_latency), 64'(m_max));
`else
    check("min_latency", 64'(min_latency), 64'(SAT));
    check("max_latency", 64'(max_latency), 64'(0));
`endif
    while (exp_q.size() > 0) begin
      check("last_latency_q", 64'(last_latency), 64'(exp_q.pop_front()));
    end
    check("last_latency", 64'(last_latency), 64'(m_last));
  endtask

  // driver tasks
  task automatic drive(input bit s, input bit r, input bit d, input bit c, input bit f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(i[0], 1, 0, 1, 0);
    reset = 1'b1;
  endtask

  task automatic run_txn(input int lat);
    if (lat == 1) begin
      drive(1, 1, 1, 1, 0);
    end else begin
      drive(1, 1, 0, 1, 0);
      idle(lat - 2);
      drive(0, 0, 1, 1, 0);
    end
    idle(1);
  endtask

  initial begin
    reset = 1'b0;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    model_reset();

    // reset with ap_start toggling
    do_reset();
    check("rst_state", 64'(state), 64'(0));
    check("rst_started", 64'(txn_started), 64'(0));
    check("rst_min", 64'(min_latency), 64'(SAT));

    // single-cycle transaction
    drive(1, 1, 1, 1, 0);
    check("t1_started", 64'(txn_started), 64'(1));
    check("t1_done", 64'(txn_done), 64'(1));
    check("t1_last", 64'(last_latency), 64'(1));
    check("t1_valid", 64'(latency_valid), 64'(1));
    check("t1_state", 64'(state), 64'(0));

    // latency 5 through RUN
    do_reset();
    drive(1, 1, 0, 1, 0);
    check("t2_state_run", 64'(state), 64'(1));
    idle(3);
    drive(0, 0, 1, 1, 0);
    check("t2_last", 64'(last_latency), 64'(5));
    check("t2_busy", 64'(busy_cycles), 64'(4));
    check("t2_state_idle", 64'(state), 64'(0));

    // DONE_WAIT with ap_continue low for 3 cycles
    do_reset();
    drive(1, 1, 0, 1, 0);
    idle(1);
    drive(0, 0, 1, 0, 0);
    check("t3_state_wait", 64'(state), 64'(2));
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    check("t3_stall", 64'(stall_cycles), 64'(3));
    check("t3_last", 64'(last_latency), 64'(6));
    check("t3_state_idle", 64'(state), 64'(0));

    // min/max over latencies 3, 7, 2
    do_reset();
    run_txn(3);
    run_txn(7);
    run_txn(2);
    check("t4_done", 64'(txn_done), 64'(3));
`ifdef NODF_MODULE_INTF_LATENCY_EN
    check("t4_min", 64'(min_latency), 64'(2));
    check("t4_max", 64'(max_latency), 64'(7));
`else
    check("t4_min", 64'(min_latency), 64'(SAT));
    check("t4_max", 64'(max_latency), 64'(0));
`endif

    // protocol error, then finish freezes counters
    do_reset();
    drive(0, 0, 1, 1, 0);
    idle(2);
    check("t5_perr", 64'(protocol_err), 64'(1));
    drive(0, 0, 0, 1, 1);
    check("t5_finished", 64'(finished), 64'(1));
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0);
    check("t5_started_frozen", 64'(txn_started), 64'(0));
    check("t5_state_frozen", 64'(state), 64'(0));

    // completion and finish in the same cycle
    do_reset();
    drive(1, 1, 0, 1, 0);
    idle(1);
    drive(0, 0, 1, 1, 1);
    check("t6_done", 64'(txn_done), 64'(1));
    check("t6_last", 64'(last_latency), 64'(3));
    run_txn(2);
    check("t6_done_frozen", 64'(txn_done), 64'(1));

    // reset mid-transaction aborts it
    do_reset();
    drive(1, 1, 0, 1, 0);
    idle(2);
    do_reset();
    check("t7_state", 64'(state), 64'(0));
    check("t7_valid", 64'(latency_valid), 64'(0));

    // saturating latency and busy counters
    drive(1, 1, 0, 1, 0);
    idle(SAT + 40);
    drive(0, 0, 1, 1, 0);
    check("t8_last_sat", 64'(last_latency), 64'(SAT));
    check("t8_busy_sat", 64'(busy_cycles), 64'(SAT));

    // random ap_ctrl traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit s, r, d, c;
      s = ($urandom_range(0, 3) == 0);
      r = s && ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 3) != 0);
      drive(s, r, d, c, (i == 2800));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
